dmem_write_buffer: RTL
======================

Name: dmem_write_buffer

Overview:
Data-memory responder on the CPU store/load interface (dmem_we, alu_out, dmem_wd). It accepts word stores into a small posted-write FIFO and drains them into an internal word RAM one per cycle when permitted. Loads see the youngest buffered data through store-to-load forwarding, so the CPU observes stores in program order. The CPU core sits on one side, and the drain throttle (drain_ok) models a busy memory on the other.

Parameters:
DEPTH, 4, number of buffer entries (power of 2, >=2)
MEM_WORDS, 256, internal RAM words; index = alu_out[9:2]
IDX_W, 8, log2(MEM_WORDS)

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high
dmem_we  in  1  store request from CPU
dmem_re  in  1  load request from CPU (qualifies dmem_rd only)
alu_out  in  32  byte address; only bits [IDX_W+1:2] used, [1:0] ignored
dmem_wd  in  32  store data
drain_ok  in  1  memory free this cycle; permits one drain
dmem_rd  out  32  load data (combinational)
stall  out  1  buffer cannot accept a store this cycle (combinational)
empty  out  1  count == 0
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (synchronous, active-high): head, tail and count go to 0. All entries are invalidated. RAM is zeroed. Pending stores are discarded, including mid-drain. After reset: stall=0, empty=1, count=0, dmem_rd=0.
- Entry fields: {idx[IDX_W-1:0], data[31:0]}. Circular FIFO with head (oldest) and tail (next free). Pointers wrap modulo DEPTH.
- stall = (count == DEPTH). It does not depend on drain in the same cycle.
- Enqueue when dmem_we && !stall. {alu_out[IDX_W+1:2], dmem_wd} is written at tail, tail advances, and the entry is visible one cycle later.
- A store arriving while stall=1 is ignored, and the entry is not written. The CPU must hold the request until stall=0.
- Drain when count>0 && drain_ok. On the edge, RAM[head.idx] <= head.data and head advances. At most one drain per cycle.
- Count update:
  - +1 on enqueue only.
  - -1 on drain only.
  - Unchanged on simultaneous enqueue+drain. Legal only when not full, since stall blocks enqueue when full.
- Read, combinational: dmem_rd = data of the youngest valid entry whose idx equals alu_out[IDX_W+1:2]. If there is no match, dmem_rd = RAM[idx].
  - Youngest means closest to tail-1, searching backward with wrap.
  - The result is valid whenever dmem_re=1. When dmem_re=0 the value is don't-care but still driven deterministically.
- Same-cycle store+load to the same idx returns the pre-store value. No same-cycle bypass from dmem_wd.
- An entry draining in the current cycle still forwards until the edge. After the edge the RAM holds the same value, so there is no gap.
- Multiple stores to one idx are all held. Each drains in order, and the final RAM value equals the last store.
- Latency: a store is visible to loads 1 cycle after acceptance. It reaches RAM no earlier than 1 cycle after acceptance, and only once it is head with drain_ok=1.

Optional Feature:
DMEM_WB_COALESCE_EN
- Defined: a store whose idx equals the youngest valid entry's idx (tail-1) overwrites that entry's data in place. Tail and count are unchanged.
  - Coalescing is allowed even when full: stall is then deasserted for that matching address, so stall = full && !(dmem_we && idx==youngest.idx).
  - Coalescing is disallowed if that entry is head and is draining this cycle. In that case the store is a normal enqueue, or stalls if full.
- Undefined: every accepted store allocates a new entry, and stall = full.

Test Plan:
1. Reset, then load idx 0x7F (alu_out=0x1FC) -> dmem_rd=0, empty=1, count=0, stall=0.
2. drain_ok=0. Store 0x4 at 0x1FC, then 0xC at 0x1F8, then load 0x1FC -> dmem_rd=0x4 (forwarded), count=2. Raise drain_ok for 2 cycles -> empty=1, RAM[0x7F]=0x4, RAM[0x7E]=0xC, load still returns 0x4.
3. drain_ok=0. Store to 0x1F4, 0x1F0, 0x1EC, 0x1E8 (0x3, 0x58, 0x2, 0x58) -> count=4, stall=1. A 5th store 0x1 at 0x1E4 is ignored. Pulse drain_ok for 1 cycle -> stall=0. Retry is accepted and count=4.
4. drain_ok=0. Store 0x11 then 0x22 to 0x1E0 -> load 0x1E0 gives 0x22. With coalescing: count=1. Without: count=2. After draining, RAM[0x78]=0x22.
5. drain_ok=1 continuously. Store every cycle to rotating addresses for 10 cycles -> count stays at most 1, stall never asserts, and after wrap-around all 10 RAM words match the data written.
6. With 3 entries buffered, assert reset for 1 cycle -> count=0, loads of those addresses return 0, stall=0.

Source files
------------

// File: rtl/dmem_write_buffer_if.sv
// CPU-side store/load bus of the data-memory write buffer.
interface dmem_write_buffer_if;
  logic        dmem_we;
  logic        dmem_re;
  logic [31:0] alu_out;
  logic [31:0] dmem_wd;
  logic [31:0] dmem_rd;
  logic        stall;

  modport master (output dmem_we, dmem_re, alu_out, dmem_wd, input dmem_rd, stall);
  modport slave  (input dmem_we, dmem_re, alu_out, dmem_wd, output dmem_rd, stall);
endinterface

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer in front of a word RAM with store-to-load forwarding; loads are combinational,
// stores visible 1 cycle after acceptance, stall when full. Optional DMEM_WB_COALESCE_EN merges into youngest entry.
module dmem_write_buffer #(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 256,
  parameter int IDX_W     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  dmem_write_buffer_if.slave       bus,
  input  logic                     drain_ok,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] ent_idx  [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [31:0]      ram      [MEM_WORDS];
  logic [PTR_W-1:0] head, tail, youngest;

  logic [IDX_W-1:0] wr_idx;
  logic             full, drain, coal, enq;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic             unused_sigs;

  assign wr_idx   = bus.alu_out[IDX_W+1:2];
  assign youngest = tail - PTR_W'(1);
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign drain    = !empty && drain_ok;

`ifdef DMEM_WB_COALESCE_EN
  // The youngest entry cannot absorb a store while it is leaving as head this cycle.
  assign coal = bus.dmem_we && !empty && (ent_idx[youngest] == wr_idx)
                && !(drain && (youngest == head));
`else
  assign coal = 1'b0;
`endif

  assign bus.stall = full && !coal;
  assign enq       = bus.dmem_we && !bus.stall && !coal;

  // Search from tail-1 backward so the youngest matching store wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!fwd_hit && (CNT_W'(i) < count)
          && (ent_idx[tail - PTR_W'(i + 1)] == wr_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[tail - PTR_W'(i + 1)];
      end
    end
  end

  assign bus.dmem_rd = fwd_hit ? fwd_data : ram[wr_idx];

  // dmem_re only qualifies the read result; the address bits outside the word index are ignored.
  assign unused_sigs = ^{bus.dmem_re, bus.alu_out[31:IDX_W+2], bus.alu_out[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_idx[i]  <= '0;
        ent_data[i] <= '0;
      end
      for (int i = 0; i < MEM_WORDS; i++) begin
        ram[i] <= '0;
      end
    end else begin
      if (enq) begin
        ent_idx[tail]  <= wr_idx;
        ent_data[tail] <= bus.dmem_wd;
        tail           <= tail + PTR_W'(1);
      end else if (coal) begin
        ent_data[youngest] <= bus.dmem_wd;
      end
      if (drain) begin
        ram[ent_idx[head]] <= ent_data[head];
        head               <= head + PTR_W'(1);
      end
      case ({enq, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
